// File: rtl/avmm_vram_arbiter.sv
// Two-master Avalon-MM arbiter for the shared VRAM port: VGA fetch (m0) has priority,
// the core (m1) is forced in after a bounded m0 run, and a tag FIFO routes read data back.
module avmm_vram_arbiter #(
  parameter int AWIDTH   = 19,
  parameter int PWIDTH   = 8,
  parameter int MAXPEND  = 4,
  parameter int BURSTMAX = 8
) (
  input  logic              clk_core,
  input  logic              rst_core,
  input  logic [AWIDTH-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [PWIDTH-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [AWIDTH-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [PWIDTH-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [PWIDTH-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [AWIDTH-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [PWIDTH-1:0] s_writedata,
  input  logic              s_waitrequest,
  input  logic [PWIDTH-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              err_spurious
);

  localparam int PTRW = $clog2(MAXPEND);
  localparam int CNTW = PTRW + 1;
  localparam int SCW  = $clog2(BURSTMAX + 1);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_M0   = 2'd1;
  localparam logic [1:0] GNT_M1   = 2'd2;

  logic [CNTW-1:0] pend_cnt_reg;
  logic [CNTW-1:0] wr_ptr_reg;
  logic [CNTW-1:0] rd_ptr_reg;
  logic            tag_mem [MAXPEND];
  logic            lock_reg;
  logic [1:0]      gnt_reg;
  logic [SCW-1:0]  starve_reg;
  logic            err_reg;

  logic       rd_ok, req1, elig0, elig1;
  logic [1:0] gnt_sel;
  logic       cmd, accept, push, pop, head_tag;

  assign rd_ok = (pend_cnt_reg < CNTW'(MAXPEND));
  assign req1  = m1_read | m1_write;
  assign elig0 = m0_read & rd_ok;
  assign elig1 = m1_write | (m1_read & rd_ok);

  always_comb begin
    gnt_sel = GNT_NONE;
    if (rst_core)
      gnt_sel = GNT_NONE;
    else if (lock_reg)
      gnt_sel = gnt_reg;
    else if (elig1 && (starve_reg == SCW'(BURSTMAX)))
      gnt_sel = GNT_M1;
    else if (elig0)
      gnt_sel = GNT_M0;
    else if (elig1)
      gnt_sel = GNT_M1;
  end

  // m1 write takes precedence over a simultaneous m1 read
  assign s_read      = ((gnt_sel == GNT_M0) & m0_read) |
                       ((gnt_sel == GNT_M1) & m1_read & ~m1_write);
  assign s_write     = (gnt_sel == GNT_M1) & m1_write;
  assign s_address   = (gnt_sel == GNT_M1) ? m1_address : m0_address;
  assign s_writedata = m1_writedata;

  assign m0_waitrequest = (gnt_sel == GNT_M0) ? s_waitrequest : 1'b1;
  assign m1_waitrequest = (gnt_sel == GNT_M1) ? s_waitrequest : 1'b1;

  assign cmd    = s_read | s_write;
  assign accept = cmd & ~s_waitrequest;
  assign push   = accept & s_read;
  assign pop    = s_readdatavalid & (pend_cnt_reg != '0) & ~rst_core;

  assign head_tag         = tag_mem[rd_ptr_reg[PTRW-1:0]];
  assign m0_readdatavalid = pop & ~head_tag;
  assign m1_readdatavalid = pop & head_tag;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign err_spurious     = err_reg;

  always_ff @(posedge clk_core) begin
    if (push)
      tag_mem[wr_ptr_reg[PTRW-1:0]] <= (gnt_sel == GNT_M1);
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      lock_reg     <= 1'b0;
      gnt_reg      <= GNT_NONE;
      starve_reg   <= '0;
      pend_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      err_reg      <= 1'b0;
    end else begin
      // a stalled command keeps its grant until the slave takes it
      lock_reg <= cmd & s_waitrequest;
      if (cmd)
        gnt_reg <= gnt_sel;

      if (!req1 || (accept && (gnt_sel == GNT_M1)))
        starve_reg <= '0;
      else if (accept && (gnt_sel == GNT_M0) && (starve_reg < SCW'(BURSTMAX)))
        starve_reg <= starve_reg + 1'b1;

      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      pend_cnt_reg <= pend_cnt_reg + CNTW'(push) - CNTW'(pop);

      if (s_readdatavalid && (pend_cnt_reg == '0))
        err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avmm_vram_arbiter.sv
// Randomized bench for avmm_vram_arbiter: bench-side masters and VRAM, with a
// queue-based reference of grants, outstanding reads and data routing.
module tb_avmm_vram_arbiter;
  localparam int AW = 19;
  localparam int PW = 8;
  localparam int MP = 4;
  localparam int BM = 8;

  logic          clk_core, rst_core;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_waitrequest, m0_readdatavalid;
  logic [PW-1:0] m0_readdata, m1_readdata, m1_writedata, s_writedata, s_readdata;
  logic          m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
  logic          s_read, s_write, s_waitrequest, s_readdatavalid, err_spurious;

  avmm_vram_arbiter #(.AWIDTH(AW), .PWIDTH(PW), .MAXPEND(MP), .BURSTMAX(BM)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .err_spurious(err_spurious)
  );

  initial begin
    clk_core = 1'b0;
    forever #5 clk_core = ~clk_core;
  end

  typedef struct { int due; logic [PW-1:0] data; } ret_t;

  int vectors = 0, miscompares = 0, cyc = 0;
  // stimulus knobs
  int p0, p1, m1_mode, p_wait, lat_lo, lat_hi;
  bit spur_en, rst_req;
  // reference state: outstanding read owners in issue order, held command, m0 run length
  int            tagq[$];
  int            held, starve;
  bit            err_m, acc0, acc1;
  logic [PW-1:0] expq0[$], expq1[$];
  logic [PW-1:0] mem [16];
  ret_t          retq[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    cyc++;
    rst_core = rst_req;
    if (rst_core) begin
      m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    end else begin
      if (!m0_read || acc0) begin
        m0_read    = ($urandom_range(0, 99) < p0);
        m0_address = AW'($urandom);
      end
      if (!(m1_read || m1_write) || acc1) begin
        int kind = (m1_mode == 1) ? 0 : $urandom_range(0, 2);
        bit go = ($urandom_range(0, 99) < p1);
        m1_read      = go && (kind != 1);
        m1_write     = go && (kind != 0);
        m1_address   = AW'($urandom);
        m1_writedata = PW'($urandom);
      end
    end
    s_waitrequest   = ($urandom_range(0, 99) < p_wait);
    s_readdatavalid = 1'b0;
    s_readdata      = PW'($urandom);
    if (retq.size() > 0 && retq[0].due == cyc) begin
      s_readdatavalid = 1'b1;
      s_readdata      = retq[0].data;
      void'(retq.pop_front());
    end else if (spur_en && retq.size() == 0 && tagq.size() == 0 && $urandom_range(0, 99) < 40) begin
      s_readdatavalid = 1'b1;
    end
  endtask

  task automatic model_check();
    int  pend  = tagq.size();
    bit  rd_ok = (pend < MP);
    bit  req1  = m1_read || m1_write;
    bit  el0   = m0_read && rd_ok;
    bit  el1   = m1_write || (m1_read && rd_ok);
    int  gnt, head;
    bit  e_rd, e_wr, pop, accept;
    logic [AW-1:0] addr;

    if (rst_core)                 gnt = -1;
    else if (held >= 0)           gnt = held;
    else if (el1 && starve == BM) gnt = 1;
    else if (el0)                 gnt = 0;
    else if (el1)                 gnt = 1;
    else                          gnt = -1;
    e_rd = (gnt == 0 && m0_read) || (gnt == 1 && m1_read && !m1_write);
    e_wr = (gnt == 1 && m1_write);
    pop  = s_readdatavalid && !rst_core && pend > 0;
    head = (pend > 0) ? tagq[0] : 0;
    addr = (gnt == 1) ? m1_address : m0_address;

    chk("m0_waitrequest", 32'(m0_waitrequest), (gnt == 0) ? 32'(s_waitrequest) : 32'd1);
    chk("m1_waitrequest", 32'(m1_waitrequest), (gnt == 1) ? 32'(s_waitrequest) : 32'd1);
    chk("s_read", 32'(s_read), 32'(e_rd));
    chk("s_write", 32'(s_write), 32'(e_wr));
    if (e_rd || e_wr) chk("s_address", 32'(s_address), 32'(addr));
    if (e_wr) chk("s_writedata", 32'(s_writedata), 32'(m1_writedata));
    chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(pop && head == 0));
    chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(pop && head == 1));
    chk("err_spurious", 32'(err_spurious), 32'(err_m));
    if (pop && head == 0 && expq0.size() > 0) begin
      chk("m0_readdata", 32'(m0_readdata), 32'(expq0.pop_front()));
      $display("cyc %0d: return m0 data %0h", cyc, m0_readdata);
    end
    if (pop && head == 1 && expq1.size() > 0) begin
      chk("m1_readdata", 32'(m1_readdata), 32'(expq1.pop_front()));
      $display("cyc %0d: return m1 data %0h", cyc, m1_readdata);
    end

    acc0 = 1'b0; acc1 = 1'b0;
    if (rst_core) begin
      tagq.delete(); expq0.delete(); expq1.delete();
      held = -1; starve = 0; err_m = 1'b0;
    end else begin
      accept = (e_rd || e_wr) && !s_waitrequest;
      held   = ((e_rd || e_wr) && s_waitrequest) ? gnt : -1;
      if (!req1 || (accept && gnt == 1))             starve = 0;
      else if (accept && gnt == 0 && starve < BM)     starve++;
      if (pop) void'(tagq.pop_front());
      if (s_readdatavalid && pend == 0) begin
        err_m = 1'b1;
        $display("cyc %0d: return with nothing pending", cyc);
      end
      if (accept && e_rd) begin
        ret_t r;
        r.due  = cyc + $urandom_range(lat_lo, lat_hi);
        if (retq.size() > 0 && r.due <= retq[$].due) r.due = retq[$].due + 1;
        r.data = mem[addr[3:0]];
        retq.push_back(r);
        tagq.push_back(gnt);
        if (gnt == 0) expq0.push_back(r.data); else expq1.push_back(r.data);
        $display("cyc %0d: m%0d read  addr %0h", cyc, gnt, addr);
      end
      if (accept && e_wr) begin
        mem[m1_address[3:0]] = m1_writedata;
        $display("cyc %0d: m1 write addr %0h data %0h", cyc, m1_address, m1_writedata);
      end
      acc0 = accept && gnt == 0;
      acc1 = accept && gnt == 1;
    end
  endtask

  task automatic step();
    @(posedge clk_core); #1;
    drive();
    @(negedge clk_core);
    model_check();
  endtask

  task automatic run(int n, int a0, int a1, int mm, int pw, int llo, int lhi);
    p0 = a0; p1 = a1; m1_mode = mm; p_wait = pw; lat_lo = llo; lat_hi = lhi;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_core = 1'b1; rst_req = 1'b1; spur_en = 1'b0;
    m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_address = '0; m1_address = '0; m1_writedata = '0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
    held = -1; starve = 0; err_m = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = PW'($urandom);

    run(3, 0, 0, 0, 0, 1, 1);                 // reset state
    rst_req = 1'b0;
    run(40, 100, 0, 0, 0, 4, 4);              // m0 back-to-back reads, latency 4
    run(60, 100, 100, 1, 0, 1, 1);            // both reading: starvation slot for m1
    run(300, 60, 60, 0, 40, 1, 6);            // mixed traffic with stalls
    run(150, 90, 70, 0, 10, 6, 8);            // long latency: FIFO fills, writes bypass
    run(20, 0, 0, 0, 0, 1, 1);                // drain

    spur_en = 1'b1;
    run(10, 0, 0, 0, 0, 1, 1);                // returns with nothing pending
    spur_en = 1'b0;
    run(30, 60, 60, 0, 30, 1, 4);             // sticky error persists

    p0 = 100; p1 = 0; p_wait = 0; lat_lo = 6; lat_hi = 6;
    for (int i = 0; i < 30 && tagq.size() < 3; i++) step();
    rst_req = 1'b1;
    step();                                   // reset with reads outstanding
    rst_req = 1'b0;
    run(15, 0, 0, 0, 0, 1, 1);                // late returns are dropped
    run(60, 70, 70, 0, 30, 1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/avmm_vram_arbiter.md
Name: avmm_vram_arbiter

Overview:
- Two-master, one-slave Avalon-MM arbiter that shares the single VRAM port between two masters.
- Master 0 is the VGA pixel fetch (read-only, high priority). Master 1 is the core/drawing engine (read/write).
- Issues commands combinationally and tracks outstanding reads in a tag FIFO, so read data returns to the master that requested it.
- A starvation guard gives master 1 a slot after a bounded run of master 0 grants.

Parameters:
- AWIDTH, 19, VRAM address width.
- PWIDTH, 8, pixel/data width.
- MAXPEND, 4, maximum outstanding reads (tag FIFO depth, power of 2, at least 2).
- BURSTMAX, 8, consecutive m0 accepts allowed while m1 is waiting, before m1 is forced in.

Ports:
- clk_core  in  1  core clock.
- rst_core  in  1  reset, synchronous, active-high.
- m0_address  in  AWIDTH  VGA read address.
- m0_read  in  1  VGA read request.
- m0_waitrequest  out  1  stall to VGA.
- m0_readdata  out  PWIDTH  read data (s_readdata broadcast).
- m0_readdatavalid  out  1  read data valid for m0.
- m1_address  in  AWIDTH  core address.
- m1_read  in  1  core read request.
- m1_write  in  1  core write request.
- m1_writedata  in  PWIDTH  core write data.
- m1_waitrequest  out  1  stall to core.
- m1_readdata  out  PWIDTH  read data (s_readdata broadcast).
- m1_readdatavalid  out  1  read data valid for m1.
- s_address  out  AWIDTH  VRAM address.
- s_read  out  1  VRAM read.
- s_write  out  1  VRAM write.
- s_writedata  out  PWIDTH  VRAM write data.
- s_waitrequest  in  1  VRAM stall.
- s_readdata  in  PWIDTH  VRAM read data.
- s_readdatavalid  in  1  VRAM read data valid.
- err_spurious  out  1  sticky flag: s_readdatavalid arrived with no read pending.

Behaviour:
- Single clock clk_core. rst_core is synchronous, active-high.
- Reset state: lock=0, starve_cnt=0, tag FIFO empty (pend_cnt=0), err_spurious=0.
- m0_waitrequest=1 and m1_waitrequest=1 whenever rst_core=1 or no grant. s_read=s_write=0 during reset.
- Requests: req0 = m0_read. req1 = m1_read | m1_write. If m1 asserts both, write wins and the read is ignored.
- rd_ok = (pend_cnt < MAXPEND); reads are blocked while the FIFO holds MAXPEND entries, even if a pop occurs that same cycle. Writes ignore rd_ok.
- elig0 = req0 & rd_ok. elig1 = m1_write | (m1_read & rd_ok).
- Grant selection, evaluated combinationally each cycle:
  - If lock=1: keep the previous grant (gnt_q).
  - Else if elig1 and starve_cnt==BURSTMAX: grant m1.
  - Else if elig0: grant m0.
  - Else if elig1: grant m1.
  - Else: no grant.
- Granted master's command drives s_* in the same cycle (zero added latency).
- Granted master's waitrequest = s_waitrequest; the other master's waitrequest = 1.
- Lock: set when a command is driven and s_waitrequest=1 (the command is held stable until accepted). Cleared on the accept cycle (command driven and s_waitrequest=0).
- Accept = command driven and s_waitrequest=0. On an accepted read, push the tag (0 or 1) into the FIFO.
- Starvation counter:
  - On m0 accept while req1=1: starve_cnt increments, saturating at BURSTMAX.
  - On m1 accept, or any cycle with req1=0: starve_cnt clears to 0.
- Read return:
  - On s_readdatavalid with FIFO non-empty: pop. mN_readdatavalid = s_readdatavalid & (head tag == N), combinational, same cycle.
  - Simultaneous push and pop: pend_cnt unchanged, order preserved.
  - s_readdatavalid with FIFO empty: no pop, both readdatavalid=0, err_spurious set. err_spurious is cleared only by reset.
- m0_readdata = m1_readdata = s_readdata.
- Reset mid-operation: lock, starve_cnt and FIFO are cleared immediately. Data returning after reset for pre-reset reads is dropped and sets err_spurious. Integration must quiesce VRAM before reset.
- Pointer wrap: FIFO pointers are log2(MAXPEND)+1 bits wide; full/empty is derived from pend_cnt.

Test Plan:
- Back-to-back m0 reads only, VRAM latency 4, no waitrequest -> 4 reads issued, 5th stalled (m0_waitrequest=1) until first readdatavalid; data returned in order with m0_readdatavalid only.
- m0 and m1 reads requested together continuously, BURSTMAX=8 -> grant pattern is 8 m0 accepts then 1 m1 accept, repeating; m1_readdatavalid aligns with the tag order.
- m1 write presented while s_waitrequest held high for 3 cycles and m0_read rises in cycle 2 -> s_address/s_writedata stay at m1 values until accept; m0 is granted the next cycle.
- FIFO full (4 pending) with m1 write pending -> write issues immediately while m0/m1 reads are stalled; pend_cnt stays 4.
- s_readdatavalid pulse with FIFO empty -> err_spurious=1 and both readdatavalid=0; err_spurious remains 1 until rst_core.
- rst_core asserted with 3 reads pending -> next cycle pend_cnt=0, both waitrequests=1; the 3 late returns are dropped and err_spurious=1.
